corr_result_serializer: RTL and testbench

Output stage of the Lab5 image-processing core. It takes 20-bit cross-correlation results from the compute datapath through a valid/ready handshake and buffers them in a small FIFO. It then emits each result MSB-first as a serial bit stream on `out_valid`/`out_value`, which is what the testbench samples. Words stream back-to-back with no idle cycle between them. A one-cycle `done` pulse follows the last bit of the final result of an action.

---
 rtl/lab5_pkg.sv | 14 +
 rtl/corr_result_serializer_if.sv | 25 ++
 rtl/res_fifo.sv | 55 +++++
 rtl/corr_result_serializer.sv | 97 +++++++++
 tb/tb_corr_result_serializer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lab5_pkg.sv
// Shared types and sizes for the Lab5 result output stage.
package lab5_pkg;

  localparam int RES_W          = 20;
  localparam int RES_FIFO_DEPTH = 4;

  typedef logic [RES_W-1:0] res_t;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } shift_state_e;

endpackage

// File: rtl/corr_result_serializer_if.sv
// Result handshake from the compute datapath into the serializer.
interface corr_result_serializer_if #(
  parameter int RES_W = lab5_pkg::RES_W
);

  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_data;
  logic             res_last;

  modport master (
    output res_valid,
    output res_data,
    output res_last,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  res_last,
    output res_ready
  );

endinterface

// File: rtl/res_fifo.sv
// Small synchronous FIFO holding {last, result} words.
module res_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= din;
    end
  end

  // Pointers are power-of-two wide, so they wrap on overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/corr_result_serializer.sv
// Buffers correlation results and streams them MSB-first, gap-free.
module corr_result_serializer #(
  parameter int RES_W      = lab5_pkg::RES_W,
  parameter int FIFO_DEPTH = lab5_pkg::RES_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  corr_result_serializer_if.slave   res,
  output logic                      out_valid,
  output logic                      out_value,
  output logic                      done
);

  import lab5_pkg::*;

  localparam int CW = $clog2(RES_W);

  shift_state_e     state;
  logic [RES_W-1:0] shreg;
  logic             last_q;
  logic [CW-1:0]    bit_cnt;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             word_end;
  logic [RES_W:0]   head;

  assign res.res_ready = !full;
  assign push          = res.res_valid && !full;
  assign word_end      = (state == S_SHIFT) &&
                         (bit_cnt == CW'(RES_W - 1));
  assign pop           = !empty &&
                         ((state == S_IDLE) || word_end);
  assign out_value     = out_valid & shreg[RES_W-1];

  res_fifo #(
    .W     (RES_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({res.res_last, res.res_data}),
    .full  (full),
    .empty (empty),
    .dout  (head)
  );

  // A reload on the final bit keeps consecutive words contiguous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      last_q    <= 1'b0;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= word_end && last_q;
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            shreg     <= head[RES_W-1:0];
            last_q    <= head[RES_W];
            bit_cnt   <= '0;
            out_valid <= 1'b1;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (pop) begin
            shreg   <= head[RES_W-1:0];
            last_q  <= head[RES_W];
            bit_cnt <= '0;
          end else if (word_end) begin
            shreg     <= '0;
            last_q    <= 1'b0;
            bit_cnt   <= '0;
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end else begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_corr_result_serializer.sv
// Bench for corr_result_serializer: tables, directed corners, random.
module tb_corr_result_serializer;

  localparam int W = 20;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic out_valid;
  logic out_value;
  logic done;

  always #5 clk = ~clk;

  corr_result_serializer_if #(.RES_W(W)) rif ();

  corr_result_serializer #(
    .RES_W      (W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res       (rif),
    .out_valid (out_valid),
    .out_value (out_value),
    .done      (done)
  );

  // Schedule model: each word starts one edge after acceptance or
  // right when the previous word's W bits are over, whichever is later.
  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           acc;
    int           s;
  } mword_t;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         l;
    logic         ev;
    logic         eb;
    logic         ed;
    logic         er;
  } vec_t;

  mword_t       mq[$];
  int           prev_end;
  int           edge_n;
  int           checks;
  int           errors;
  logic [W-1:0] rx_sh;
  int           rx_n;
  logic [W-1:0] rx[$];
  int           done_edges[$];
  int           acc_edges[$];
  int           vcnt;
  int           run;
  int           maxrun;
  int           hi_cnt;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at edge %0d",
               name, act, exp, edge_n);
    end
  endtask

  task automatic model_out(input int l, output logic ev,
                           output logic eb, output logic ed,
                           output logic er);
    int n;
    ev = 1'b0;
    eb = 1'b0;
    ed = 1'b0;
    n  = 0;
    foreach (mq[i]) begin
      if (mq[i].s <= l && l <= mq[i].s + W - 1) begin
        ev = 1'b1;
        eb = mq[i].data[W-1-(l-mq[i].s)];
      end
      if (mq[i].last && mq[i].s + W == l) ed = 1'b1;
      if (mq[i].s >= l + 1) n++;
    end
    er = (n < D);
  endtask

  // Called at a negedge: check this cycle, drive the next edge.
  task automatic tick(input logic v, input logic [W-1:0] d,
                      input logic l, input logic rst,
                      output logic acc);
    logic ev, eb, ed, er;
    int   s;
    model_out(edge_n, ev, eb, ed, er);
    chk("out_valid", out_valid, ev);
    chk("out_value", out_value, eb);
    chk("done", done, ed);
    chk("res_ready", rif.res_ready, er);
    if (out_valid !== 1'b0 || out_value !== 1'b0) hi_cnt++;
    if (out_valid === 1'b1) begin
      rx_sh = {rx_sh[W-2:0], out_value};
      rx_n++;
      vcnt++;
      run++;
      if (run > maxrun) maxrun = run;
      if (rx_n == W) begin
        rx.push_back(rx_sh);
        rx_n = 0;
      end
    end else begin
      run = 0;
    end
    if (done === 1'b1) done_edges.push_back(edge_n);
    rif.res_valid = v;
    rif.res_data  = d;
    rif.res_last  = l;
    rst_n         = !rst;
    acc = v && (rif.res_ready === 1'b1) && !rst;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      mq.delete();
      prev_end = 0;
      rx_n     = 0;
    end else if (acc) begin
      s = (edge_n + 1 > prev_end) ? edge_n + 1 : prev_end;
      mq.push_back('{d, l, edge_n, s});
      prev_end = s + W;
      acc_edges.push_back(edge_n);
    end
    while (mq.size() > 0 && mq[0].s + W < edge_n) void'(mq.pop_front());
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0, a);
  endtask

  initial begin
    logic         a;
    vec_t         tbl[24];
    logic [W-1:0] pat;
    logic [W-1:0] rd;
    logic [W-1:0] sent[$];
    int           exp_off[8];
    int           a0;
    int           cur;
    int           guard;
    int           prob[5];

    checks   = 0;
    errors   = 0;
    edge_n   = 0;
    prev_end = 0;
    rx_n     = 0;
    rx_sh    = '0;
    vcnt     = 0;
    run      = 0;
    maxrun   = 0;
    hi_cnt   = 0;

    pat    = 20'b1010_0101_1010_0101_1010;
    tbl[0] = '{1'b1, 20'hA5A5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 2; k < 22; k++)
      tbl[k] = '{1'b0, '0, 1'b0, 1'b1, pat[21-k], 1'b0, 1'b1};
    tbl[22] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[23] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_off = '{0, 1, 2, 3, 4, 22, 42, 62};
    prob    = '{20, 60, 95, 40, 100};

    rst_n         = 1'b0;
    rif.res_valid = 1'b0;
    rif.res_data  = '0;
    rif.res_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_value", out_value, 0);
    chk("rst_done", done, 0);
    chk("rst_res_ready", rif.res_ready, 1);

    // Single word from the table.
    for (int k = 0; k < 24; k++) begin
      chk("tbl_valid", out_valid, tbl[k].ev);
      chk("tbl_value", out_value, tbl[k].eb);
      chk("tbl_done", done, tbl[k].ed);
      chk("tbl_ready", rif.res_ready, tbl[k].er);
      tick(tbl[k].v, tbl[k].d, tbl[k].l, 1'b0, a);
    end

    // Back-to-back words.
    rx.delete(); done_edges.delete(); acc_edges.delete();
    vcnt = 0; run = 0; maxrun = 0;
    tick(1'b1, 20'hFFFFF, 1'b0, 1'b0, a);
    tick(1'b1, 20'h00001, 1'b0, 1'b0, a);
    tick(1'b1, 20'h80000, 1'b1, 1'b0, a);
    idle(70);
    chk("b2b_accepts", acc_edges.size(), 3);
    chk("b2b_words", rx.size(), 3);
    if (rx.size() == 3) begin
      chk("b2b_word0", rx[0], 20'hFFFFF);
      chk("b2b_word1", rx[1], 20'h00001);
      chk("b2b_word2", rx[2], 20'h80000);
    end
    chk("b2b_valid_cycles", vcnt, 60);
    chk("b2b_contiguous", maxrun, 60);
    chk("b2b_done_count", done_edges.size(), 1);
    if (done_edges.size() > 0 && acc_edges.size() > 0)
      chk("b2b_done_pos", done_edges[0] - acc_edges[0], 61);

    // Backpressure with held valid and counting data.
    rx.delete(); acc_edges.delete();
    cur = 1; guard = 0;
    while (acc_edges.size() < 8 && guard < 400) begin
      tick(1'b1, W'(cur), cur == 8, 1'b0, a);
      if (a) cur++;
      guard++;
    end
    chk("bp_timeout", guard < 400, 1);
    idle(200);
    chk("bp_accepts", acc_edges.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < acc_edges.size())
        chk((i == 5) ? "fullpop_accept" : "bp_accept_edge",
            acc_edges[i] - acc_edges[0], exp_off[i]);
    end
    chk("bp_words", rx.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < rx.size()) chk("bp_order", rx[i], i + 1);
    end

    // Reset while bit 7 of a word is on the line.
    rx.delete(); acc_edges.delete();
    tick(1'b1, 20'hFEDCB, 1'b1, 1'b0, a);
    tick(1'b1, 20'h33333, 1'b1, 1'b0, a);
    a0 = (acc_edges.size() > 0) ? acc_edges[0] : edge_n;
    guard = 0;
    while (edge_n < a0 + 8 && guard < 50) begin
      idle(1);
      guard++;
    end
    tick(1'b0, '0, 1'b0, 1'b1, a);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_value", out_value, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", rif.res_ready, 1);
    vcnt = 0;
    rx.delete();
    idle(40);
    chk("mid_rst_no_bits", vcnt, 0);
    tick(1'b1, 20'h12345, 1'b0, 1'b0, a);
    idle(25);
    chk("post_rst_words", rx.size(), 1);
    if (rx.size() > 0) chk("post_rst_word", rx[0], 20'h12345);

    // Quiet line after reset.
    tick(1'b0, '0, 1'b0, 1'b1, a);
    hi_cnt = 0;
    idle(100);
    chk("idle_quiet", hi_cnt, 0);

    // Random traffic against the schedule model.
    sent.delete(); rx.delete();
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 300; i++) begin
        rd = W'($urandom);
        tick($urandom_range(0, 99) < prob[c], rd,
             $urandom_range(0, 3) == 0, 1'b0, a);
        if (a) sent.push_back(rd);
      end
    end
    idle(150);
    chk("rand_words", rx.size(), sent.size());
    foreach (sent[i]) begin
      if (i < rx.size()) chk("rand_word", rx[i], sent[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
